// File: rtl/mdu_core_if.sv
// ---------------------------------------------------------------------------
// mdu_core_if
//   Request/result bundle between the E stage and the multiply/divide unit.
//   master : the E stage (drives start/op/a/b, observes busy/hi/lo)
//   slave  : mdu_core   (consumes the request, owns busy/hi/lo)
//   start  1  MD instruction valid this cycle
//   op     3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   a, b   32 forwarded rs / rt operands
//   busy   1  mult/div in flight (hazard-unit stall source)
//   hi, lo 32 architectural HI/LO registers
// ---------------------------------------------------------------------------
interface mdu_core_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input  busy, hi, lo);
   modport slave  (input  start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// ---------------------------------------------------------------------------
// mdu_core
//   Multi-cycle multiply/divide unit with HI/LO ownership. A mult/div start
//   latches its operands, holds busy for a fixed MULT_CYCLES / DIV_CYCLES
//   period and commits HI/LO on the edge busy falls. mthi/mtlo write
//   immediately with no busy time.
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low; clears all state
//   bus    slave modport of mdu_core_if (start/op/a/b in, busy/hi/lo out)
// ---------------------------------------------------------------------------
module mdu_core #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   mdu_core_if.slave bus
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [1:0]  r_op;     // low op bits suffice once in RUN: mult/multu/div/divu
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_busy;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
   // without relying on tool behaviour for signed overflow. Returns {rem, quo}.
   function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                              input logic signed [31:0] d);
      logic [31:0] mag_n;
      logic [31:0] mag_d;
      logic [31:0] q_u;
      logic [31:0] r_u;
      logic [31:0] q;
      logic [31:0] r;
      if (d == 32'sd0) return 64'd0;
      mag_n = n[31] ? (~n + 32'd1) : n;
      mag_d = d[31] ? (~d + 32'd1) : d;
      q_u   = mag_n / mag_d;
      r_u   = mag_n % mag_d;
      q     = (n[31] ^ d[31]) ? (~q_u + 32'd1) : q_u;
      r     = n[31] ? (~r_u + 32'd1) : r_u;
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] n,
                                                input logic [31:0] d);
      if (d == 32'd0) return 64'd0;
      return {n % d, n / d};
   endfunction

   logic signed [63:0] w_mul_s;
   logic        [63:0] w_mul_u;
   logic        [63:0] w_div_s;
   logic        [63:0] w_div_u;
   logic               w_b_zero;

   assign w_mul_s  = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_mul_u  = {32'd0, r_a} * {32'd0, r_b};
   assign w_div_s  = div_signed($signed(r_a), $signed(r_b));
   assign w_div_u  = div_unsigned(r_a, r_b);
   assign w_b_zero = (r_b == 32'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_op    <= 2'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_busy  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        r_op    <= bus.op[1:0];
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_cnt   <= bus.op[1] ? DIV_LOAD : MULT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                     end
                     OP_MTHI: r_hi <= bus.a;
                     OP_MTLO: r_lo <= bus.a;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               // start is deliberately ignored here; the hazard unit never issues it.
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  unique case (r_op)
                     2'b00: {r_hi, r_lo} <= w_mul_s;
                     2'b01: {r_hi, r_lo} <= w_mul_u;
                     2'b10: if (!w_b_zero) {r_hi, r_lo} <= w_div_s;
                     2'b11: if (!w_b_zero) {r_hi, r_lo} <= w_div_u;
                  endcase
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_core.sv
// ---------------------------------------------------------------------------
// tb_mdu_core
//   Table-driven vectors plus a few hand-built sequences for mdu_core.
//   Expected HI/LO and busy length are queued when an operation is driven and
//   popped when the unit returns to idle.
// ---------------------------------------------------------------------------
module tb_mdu_core;

   logic clk;
   logic reset;

   mdu_core_if bus ();

   mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        sb[$];
   int          n_pass;
   int          n_total;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
   endtask

   // Reference behaviour; signed divide done in 64-bit so INT_MIN/-1 fits.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
      longint sa;
      longint sbv;
      longint q;
      longint r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         3'b000: return 64'(sa * sbv);
         3'b001: return {32'd0, a} * {32'd0, b};
         3'b010: begin
            if (b == 32'd0) return {h, l};
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
         end
         3'b011: begin
            if (b == 32'd0) return {h, l};
            return {a % b, a / b};
         end
         3'b100: return {a, l};
         3'b101: return {h, a};
         default: return {h, l};
      endcase
   endfunction

   function automatic int lat(input logic [2:0] op);
      if (op < 3'd2) return 5;
      if (op < 3'd4) return 10;
      return 0;
   endfunction

   // Drive one op, scramble operands after the start edge, optionally inject a
   // start during RUN over busy cycles [inj_from, inj_to], then check results.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int en,
                        input int inj_from, input int inj_to,
                        input logic [2:0] inj_op, input logic [31:0] inj_a);
      exp_t e;
      int   k;
      bit   held;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      sb.push_back('{ehi, elo, en});
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      k    = 0;
      held = 1'b1;
      while (bus.busy && k < 40) begin
         k++;
         if (bus.hi !== m_hi || bus.lo !== m_lo) held = 1'b0;
         if (k >= inj_from && k <= inj_to) begin
            bus.start = 1'b1;
            bus.op    = inj_op;
            bus.a     = inj_a;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      chk($sformatf("busy_cycles op%0d", op), 64'(k), 64'(e.n));
      chk($sformatf("hi op%0d", op), 64'(bus.hi), 64'(e.hi));
      chk($sformatf("lo op%0d", op), 64'(bus.lo), 64'(e.lo));
      if (en > 0) chk($sformatf("hold op%0d", op), 64'(held), 64'd1);
      m_hi = e.hi;
      m_lo = e.lo;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   vec_t tbl[16];

   initial begin
      logic [63:0] mr;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      tbl[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
      tbl[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      tbl[3]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      tbl[4]  = '{3'b100, 32'h00001111, 32'h00000000, 32'h00001111, 32'h80000000, 0};
      tbl[5]  = '{3'b101, 32'h00002222, 32'h00000000, 32'h00001111, 32'h00002222, 0};
      tbl[6]  = '{3'b011, 32'h00000005, 32'h00000000, 32'h00001111, 32'h00002222, 10};
      tbl[7]  = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
      tbl[8]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      tbl[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      tbl[10] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      tbl[11] = '{3'b110, 32'h00001234, 32'h00005678, 32'hFFFFFFFE, 32'h00000001, 0};
      tbl[12] = '{3'b010, 32'h00000009, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 10};
      tbl[13] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
      tbl[14] = '{3'b111, 32'hCAFEF00D, 32'h00000001, 32'h00000000, 32'h00000001, 0};
      tbl[15] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};

      n_pass    = 0;
      n_total   = 0;
      m_hi      = 32'd0;
      m_lo      = 32'd0;
      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a     = 32'd0;
      bus.b     = 32'd0;

      reset = 1'b0;
      #1;
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_hi", 64'(bus.hi), 64'd0);
      chk("reset_lo", 64'(bus.lo), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++)
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].n,
               99, 0, 3'b000, 32'd0);

      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(0, 5));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         mr  = model(rop, ra, rb, m_hi, m_lo);
         do_op(rop, ra, rb, mr[63:32], mr[31:0], lat(rop), 99, 0, 3'b000, 32'd0);
      end

      // mtlo pulsed during a divide must be ignored.
      do_op(3'b010, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3, 3, 3'b101, 32'h0000DEAD);
      // Restart one cycle after busy falls.
      do_op(3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 5, 99, 0, 3'b000, 32'd0);

      // start held through the commit edge is still ignored; the following
      // mthi is accepted on the next edge.
      do_op(3'b001, 32'd2, 32'd3, 32'd0, 32'd6, 5, 1, 99, 3'b101, 32'h0000BEEF);
      do_op(3'b100, 32'h0000ABCD, 32'd0, 32'h0000ABCD, 32'd6, 0, 99, 0, 3'b000, 32'd0);

      // Reset mid-run discards the in-flight product.
      bus.start = 1'b1;
      bus.op    = 3'b000;
      bus.a     = 32'd3;
      bus.b     = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_busy", 64'(bus.busy), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
      chk("midrun_reset_hi", 64'(bus.hi), 64'd0);
      chk("midrun_reset_lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("post_reset_busy", 64'(bus.busy), 64'd0);
      chk("post_reset_hi", 64'(bus.hi), 64'd0);
      chk("post_reset_lo", 64'(bus.lo), 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      do_op(3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 5, 99, 0, 3'b000, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
